// File: rtl/ervp_apb_initiator_pkg.sv
// Shared types and helpers for the single-outstanding APB initiator.
package ervp_apb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_init_state_e;

  // Response status field values
  localparam logic RSP_OKAY    = 1'b0;
  localparam logic RSP_ERR     = 1'b1;
  localparam logic RSP_NO_TMO  = 1'b0;
  localparam logic RSP_TMO     = 1'b1;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Counter width able to hold TIMEOUT_CYCLES; never narrower than one bit
  function automatic int tmo_width(input int cycles);
    int w;
    w = log2_ceil(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ervp_apb_initiator_timer.sv
// Saturating ACCESS-phase counter; flags the last permitted ACCESS cycle.
module ervp_apb_initiator_timer
  import ervp_apb_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int BW_CNT = tmo_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(TIMEOUT_CYCLES - 1);
      localparam logic [BW_CNT-1:0] CNT_MAX  = '1;
      logic [BW_CNT-1:0] cnt;

      // Count ACCESS cycles, holding at the top value instead of wrapping
      always_ff @(posedge clk) begin
        if (rst || clr)                 cnt <= '0;
        else if (en && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
      end

      assign expired = (cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/ervp_apb_initiator.sv
// Valid/ready command stream to APB setup/access transfers, with timeout.
module ervp_apb_initiator
  import ervp_apb_initiator_pkg::*;
#(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BW_ADDR-1:0] req_addr,
  input  logic               req_write,
  input  logic [BW_DATA-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BW_DATA-1:0] rsp_rdata,
  output logic               rsp_slverr,
  output logic               rsp_timeout,
  output logic               busy,
  output logic               rpsel,
  output logic               rpenable,
  output logic               rpwrite,
  output logic [BW_ADDR-1:0] rpaddr,
  output logic [BW_DATA-1:0] rpwdata,
  input  logic [BW_DATA-1:0] rprdata,
  input  logic               rpready,
  input  logic               rpslverr
);

  apb_init_state_e state, state_n;

  logic [BW_ADDR-1:0] addr_q;
  logic               write_q;
  logic [BW_DATA-1:0] wdata_q;
  logic [BW_DATA-1:0] rdata_q;
  logic               slverr_q;
  logic               timeout_q;
  logic               accept;
  logic               tmo_expired;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  ervp_apb_initiator_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == ACCESS),
    .expired(tmo_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: completion from the slave wins over a same-cycle timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid)               state_n = SETUP;
      SETUP:                                state_n = ACCESS;
      ACCESS:  if (rpready || tmo_expired)  state_n = RESP;
      RESP:    if (rsp_ready)               state_n = IDLE;
      default:                              state_n = IDLE;
    endcase
  end

  // Command latch and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= RSP_OKAY;
      timeout_q <= RSP_NO_TMO;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_write ? req_wdata : '0;
      end
      if (state == ACCESS) begin
        if (rpready) begin
          rdata_q   <= write_q ? '0 : rprdata;
          slverr_q  <= rpslverr;
          timeout_q <= RSP_NO_TMO;
        end else if (tmo_expired) begin
          rdata_q   <= '1;
          slverr_q  <= RSP_ERR;
          timeout_q <= RSP_TMO;
        end
      end
    end
  end

  assign rpsel       = (state == SETUP) || (state == ACCESS);
  assign rpenable    = (state == ACCESS);
  assign rpaddr      = addr_q;
  assign rpwrite     = write_q;
  assign rpwdata     = wdata_q;
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = timeout_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ervp_apb_initiator.sv
// Directed bench for ervp_apb_initiator with a small scripted APB slave.
module tb_ervp_apb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        busy, rpsel, rpenable, rpwrite;
  logic [31:0] rpaddr, rpwdata, rprdata;
  logic        rpready, rpslverr;

  int checks = 0;
  int errors = 0;

  ervp_apb_initiator #(.BW_ADDR(32), .BW_DATA(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
    .rpsel(rpsel), .rpenable(rpenable), .rpwrite(rpwrite),
    .rpaddr(rpaddr), .rpwdata(rpwdata), .rprdata(rprdata),
    .rpready(rpready), .rpslverr(rpslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and play the slave: rpready rises on ACCESS cycle
  // index 'waits' (0-based); waits<0 never answers. Returns edges from the
  // accept edge to rsp_valid and the number of rpsel cycles.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int waits, input logic [31:0] sd, input logic se,
                      output int lat, output int sel_cyc);
    int acc;
    acc = 0; lat = 0; sel_cyc = 0;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    tick(); lat++;
    req_valid = 1'b0; req_addr = ~a; req_write = ~w; req_wdata = ~d;
    while (!rsp_valid && lat < 40) begin
      if (rpsel) begin
        sel_cyc++;
        chk("rpaddr_hold", rpaddr, a);
        chk("rpwrite_hold", {31'd0, rpwrite}, {31'd0, w});
        chk("rpwdata_hold", rpwdata, w ? d : 32'd0);
      end
      if (rpenable) begin
        rpready = (acc == waits); rprdata = sd; rpslverr = se; acc++;
      end else begin
        rpready = 1'b0;
      end
      tick(); lat++;
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    chk("rpsel_low_in_resp", {31'd0, rpsel}, 32'd0);
    rpready = 1'b0; rprdata = 32'h0BAD_0BAD; rpslverr = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat, sel;
    logic [31:0] held;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; rprdata = '0; rpready = 1'b0; rpslverr = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rpsel", {31'd0, rpsel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rpaddr", rpaddr, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    tick();

    // Read, zero wait states
    xfer(32'h100, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, lat, sel);
    chk("rd_lat", lat, 3);
    chk("rd_sel_cyc", sel, 2);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_slverr", {31'd0, rsp_slverr}, 32'd0);
    chk("rd_tmo", {31'd0, rsp_timeout}, 32'd0);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    consume();

    // Write, two wait states, slave error
    xfer(32'h204, 1'b1, 32'hA5A5A5A5, 2, 32'h1234_5678, 1'b1, lat, sel);
    chk("wr_lat", lat, 5);
    chk("wr_sel_cyc", sel, 4);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_slverr", {31'd0, rsp_slverr}, 32'd1);
    chk("wr_tmo", {31'd0, rsp_timeout}, 32'd0);
    consume();

    // Timeout: slave never answers
    xfer(32'h308, 1'b0, 32'h0, -1, 32'h5555_5555, 1'b0, lat, sel);
    chk("tmo_lat", lat, 10);
    chk("tmo_sel_cyc", sel, 9);
    chk("tmo_rdata", rsp_rdata, 32'hFFFFFFFF);
    chk("tmo_slverr", {31'd0, rsp_slverr}, 32'd1);
    chk("tmo_flag", {31'd0, rsp_timeout}, 32'd1);
    consume();

    // Timeout race: answer on the 8th ACCESS cycle
    xfer(32'h30C, 1'b0, 32'h0, 7, 32'hCAFE_F00D, 1'b0, lat, sel);
    chk("race_lat", lat, 10);
    chk("race_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("race_slverr", {31'd0, rsp_slverr}, 32'd0);
    chk("race_tmo", {31'd0, rsp_timeout}, 32'd0);
    consume();

    // Response backpressure with a second command waiting
    xfer(32'h400, 1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0, lat, sel);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'h13579BDF);
    req_valid = 1'b1; req_addr = 32'h404; req_write = 1'b1; req_wdata = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_stable", rsp_rdata, 32'h13579BDF);
      chk("bp_no_sel", {31'd0, rpsel}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
    xfer(32'h404, 1'b1, 32'h0F0F0F0F, 0, 32'h0, 1'b0, lat, sel);
    chk("bp2_lat", lat, 3);
    chk("bp2_rdata", rsp_rdata, 32'h0);
    consume();

    // Reset during an ACCESS wait state
    req_valid = 1'b1; req_addr = 32'h500; req_write = 1'b1; req_wdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_in_access", {31'd0, rpenable}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rpsel", {31'd0, rpsel}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_req_ready_in_rst", {31'd0, req_ready}, 32'd0);
    chk("mid_rpwdata", rpwdata, 32'd0);
    rst = 1'b0; #1;
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    xfer(32'h600, 1'b0, 32'h0, 0, 32'h2468_ACE0, 1'b0, lat, sel);
    chk("recover_lat", lat, 3);
    chk("recover_rdata", rsp_rdata, 32'h2468ACE0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
